alu_decode_stage: RTL and testbench
===================================

// Module: alu_decode_stage
// PURPOSE
//  Producer end of the ALU control interface: decodes RV32I instruction words into the 4-bit ALU control code,
//  operand selects and immediate consumed by the EX-stage ALU. Sits between ID and EX as one registered pipeline
//  stage with valid/ready handshake, stall hold and flush. Decode is combinational; outputs are registered.
// PARAMETERS
//  XLEN        32   datapath / immediate width
//  PC_W        32   program-counter width carried alongside the instruction
// PORTS
//  clk           in   1     single clock, all state on rising edge
//  rst           in   1     synchronous, active-high reset
//  in_valid      in   1     ID presents instruction
//  in_ready      out  1     stage can accept this cycle
//  in_instr      in   32    instruction word
//  in_pc         in   PC_W  instruction PC
//  flush         in   1     kill held/incoming op (branch mispredict, trap)
//  out_valid     out  1     decoded op valid for EX
//  out_ready     in   1     EX accepts op
//  out_alu_ctrl  out  4     ALU control code
//  out_sel_a_pc  out  1     1: ALU A = PC, 0: A = rs1
//  out_sel_b_imm out  1     1: ALU B = imm, 0: B = rs2
//  out_imm       out  XLEN  sign-extended immediate
//  out_pc        out  PC_W  PC passed through
//  out_illegal   out  1     instruction not decodable
// BEHAVIOUR
//  - ALU codes: ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, SLT 0010, SLTU 0011, SLL 0001, SRL 0101,
//    SRA 1101, PASSB 1110 (LUI). No other code is ever emitted.
//  - OP 0110011: funct3 selects op; funct7=0000000 normal, 0100000 allowed only for f3=000 (SUB) / 101 (SRA);
//    any other funct7 -> illegal.
//  - OP-IMM 0010011: same map, sel_b_imm=1; no SUBI; f3=001 requires imm[11:5]=0; f3=101 imm[11:5]
//    0000000 -> SRL, 0100000 -> SRA, else illegal.
//  - LUI -> PASSB, imm=U. AUIPC -> ADD, sel_a_pc=1, imm=U. LOAD/STORE/JALR -> ADD with I/S imm. JAL -> ADD, sel_a_pc, J imm.
//  - BRANCH: BEQ/BNE -> SUB; BLT/BGE -> SLT; BLTU/BGEU -> SLTU; imm=B, sel_b_imm=0; f3 010/011 illegal.
//  - Unknown opcode or illegal field: illegal=1, alu_ctrl=0000, sel_a_pc=0, sel_b_imm=0, imm=0; still
//    handshaked so the trap unit sees it.
//  - Latency 1 cycle: op accepted at edge N appears on out_* after edge N.
//  - in_ready = !out_valid || out_ready (combinational). Transfer in when in_valid && in_ready.
//  - Stall: out_valid && !out_ready -> all out_* hold bit-exact; in_ready=0.
//  - Simultaneous out-transfer and in-transfer: new op replaces old in same edge, out_valid stays 1.
//  - Out-transfer with no in_valid: out_valid -> 0 next cycle; payload don't-care but must not be X.
//  - flush priority over everything except rst: next cycle out_valid=0, incoming op dropped.
//  - rst: next cycle all outputs 0 (out_valid=0, alu_ctrl=0000, imm=0, illegal=0); in_ready=1 after reset.
//    Reset mid-stall discards held op.
// STRUCTURE
//  - alu_pkg: typedef enum logic [3:0] alu_ctrl_e with codes above; localparams for RV32I opcodes and funct7
//    values; packed struct dec_op_t {alu_ctrl, sel_a_pc, sel_b_imm, imm, illegal}.
//  - Sub-module alu_ctrl_decoder: pure combinational instr -> dec_op_t; this module adds pipeline register,
//    handshake and flush.
// TESTING
//  - add x1,x2,x3 0x003100B3 -> ctrl 0000, sel_b_imm=0, illegal=0, one cycle later.
//  - sub 0x403100B3 -> 1000; srai x1,x2,3 0x40315093 -> 1101, sel_b_imm=1, imm=3.
//  - lui x1,0x12345 0x123450B7 -> 1110, imm=0x12345000; auipc same imm, pc=0x100 -> ADD, sel_a_pc=1, out_pc=0x100.
//  - mul 0x023100B3 -> illegal=1, ctrl 0000; blt x2,x3 0x00314463 -> 0010; bgeu 0x00317463 -> 0011.
//  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held; release -> next op follows, no loss or duplication.
//  - flush with in_valid=1 and a held op -> out_valid=0 next cycle; rst during stall -> all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, RV32I opcode constants and decoded-op struct
// Shared by the decoder and the decode stage. Exports alu_ctrl_e, the opcode and
// funct7 constants, the dec_op_t record, and op_from_f3() that maps funct3 to an ALU code.
package alu_pkg;

  localparam int DEC_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_SRA   = 4'b1101,
    ALU_PASSB = 4'b1110
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_NORMAL = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    alu_ctrl_e             alu_ctrl;
    logic                  sel_a_pc;
    logic                  sel_b_imm;
    logic [DEC_XLEN-1:0]   imm;
    logic                  illegal;
  } dec_op_t;

  // alt selects the funct7=0100000 variant: SUB for 000, SRA for 101.
  function automatic alu_ctrl_e op_from_f3(input logic [2:0] f3, input logic alt);
    alu_ctrl_e r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// rtl/alu_ctrl_decoder.sv - combinational RV32I word to ALU control decode
// Ports: instr (32-bit instruction word) in, dec (dec_op_t) out.
// An undecodable word yields illegal=1 with every other field zero.
module alu_ctrl_decoder
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_op_t     dec
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  logic        bad;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // Shift immediates carry only the shamt; imm[11:5] is an opcode extension.
  assign shamt = {27'b0, instr[24:20]};

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f7 == F7_NORMAL)
          dec.alu_ctrl = op_from_f3(f3, 1'b0);
        else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101))
          dec.alu_ctrl = op_from_f3(f3, 1'b1);
        else
          bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.sel_b_imm = 1'b1;
        case (f3)
          3'b001: begin
            dec.alu_ctrl = ALU_SLL;
            dec.imm      = shamt;
            bad          = (f7 != F7_NORMAL);
          end
          3'b101: begin
            dec.imm = shamt;
            if (f7 == F7_NORMAL)   dec.alu_ctrl = ALU_SRL;
            else if (f7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
            else                   bad = 1'b1;
          end
          default: begin
            dec.alu_ctrl = op_from_f3(f3, 1'b0);
            dec.imm      = imm_i;
          end
        endcase
      end
      OPC_LUI: begin
        dec.alu_ctrl  = ALU_PASSB;
        dec.sel_b_imm = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_AUIPC: begin
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
        dec.imm       = imm_u;
      end
      OPC_LOAD, OPC_JALR: begin
        dec.sel_b_imm = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_STORE: begin
        dec.sel_b_imm = 1'b1;
        dec.imm       = imm_s;
      end
      OPC_JAL: begin
        dec.sel_a_pc  = 1'b1;
        dec.sel_b_imm = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b;
        case (f3[2:1])
          2'b00:   dec.alu_ctrl = ALU_SUB;
          2'b10:   dec.alu_ctrl = ALU_SLT;
          2'b11:   dec.alu_ctrl = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - registered ID/EX decode stage producing ALU control
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_instr/in_pc from ID;
// flush kills held and incoming op; out_valid/out_ready handshake to EX with
// out_alu_ctrl, out_sel_a_pc, out_sel_b_imm, out_imm, out_pc, out_illegal.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_sel_a_pc,
  output logic            out_sel_b_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  dec_op_t         dec;
  dec_op_t         op_q;
  logic [PC_W-1:0] pc_q;

  alu_ctrl_decoder u_dec (
    .instr (in_instr),
    .dec   (dec)
  );

  assign in_ready = !out_valid || out_ready;

  // Payload only changes on an accepted op, so a stall holds it bit-exact and
  // a drained slot keeps the last (defined) payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      op_q      <= '0;
      pc_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      op_q      <= dec;
      pc_q      <= in_pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_alu_ctrl  = op_q.alu_ctrl;
  assign out_sel_a_pc  = op_q.sel_a_pc;
  assign out_sel_b_imm = op_q.sel_b_imm;
  assign out_imm       = op_q.imm;
  assign out_pc        = pc_q;
  assign out_illegal   = op_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - self-checking bench for alu_decode_stage
module tb_alu_decode_stage;

  localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b1000, C_AND = 4'b0111, C_OR = 4'b0110,
                         C_XOR = 4'b0100, C_SLT = 4'b0010, C_SLTU = 4'b0011, C_SLL = 4'b0001,
                         C_SRL = 4'b0101, C_SRA = 4'b1101, C_PASSB = 4'b1110;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [3:0]  out_alu_ctrl;
  logic        out_sel_a_pc, out_sel_b_imm, out_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctrl(out_alu_ctrl), .out_sel_a_pc(out_sel_a_pc), .out_sel_b_imm(out_sel_b_imm),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [3:0]  ctrl;
    logic        sela;
    logic        selb;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic        sela;
    logic        selb;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [31:0] w, input logic [31:0] pc, input logic [3:0] c,
                              input logic a, input logic b, input logic [31:0] imm, input logic ill);
    vec_t v;
    v.instr = w; v.pc = pc; v.ctrl = c; v.sela = a; v.selb = b; v.imm = imm; v.ill = ill;
    return v;
  endfunction

  // Reference decode written from the instruction-set rules with arithmetic shifts.
  function automatic exp_t ref_model(input logic [31:0] w);
    exp_t        e;
    logic [3:0]  f3map [8];
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii, si, bi, ui, ji;
    f3map = '{C_ADD, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_OR, C_AND};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ii = $signed(w) >>> 20;
    si = $signed({w[31:25], w[11:7], 20'b0}) >>> 20;
    bi = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0, 19'b0}) >>> 19;
    ui = {w[31:12], 12'b0};
    ji = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0, 11'b0}) >>> 11;
    e = '{C_ADD, 1'b0, 1'b0, 32'h0, 1'b0};
    if (opc == 7'h33) begin
      if (f7 == 7'h00) e.ctrl = f3map[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.ctrl = C_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = C_SRA;
      else e.ill = 1'b1;
    end else if (opc == 7'h13) begin
      e.selb = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = {27'b0, w[24:20]};
        if (f7 == 7'h00) e.ctrl = f3map[f3];
        else if (f7 == 7'h20 && f3 == 3'd5) e.ctrl = C_SRA;
        else e.ill = 1'b1;
      end else begin
        e.ctrl = f3map[f3];
        e.imm  = ii;
      end
    end else if (opc == 7'h37) begin
      e.ctrl = C_PASSB; e.selb = 1'b1; e.imm = ui;
    end else if (opc == 7'h17) begin
      e.sela = 1'b1; e.selb = 1'b1; e.imm = ui;
    end else if (opc == 7'h03 || opc == 7'h67) begin
      e.selb = 1'b1; e.imm = ii;
    end else if (opc == 7'h23) begin
      e.selb = 1'b1; e.imm = si;
    end else if (opc == 7'h6f) begin
      e.sela = 1'b1; e.selb = 1'b1; e.imm = ji;
    end else if (opc == 7'h63) begin
      e.imm = bi;
      if (f3 == 3'd0 || f3 == 3'd1) e.ctrl = C_SUB;
      else if (f3 == 3'd4 || f3 == 3'd5) e.ctrl = C_SLT;
      else if (f3 == 3'd6 || f3 == 3'd7) e.ctrl = C_SLTU;
      else e.ill = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e = '{C_ADD, 1'b0, 1'b0, 32'h0, 1'b1};
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  pool [10];
    logic [31:0] w;
    pool = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h67, 7'h6f, 7'h63, 7'h7f};
    w = {$urandom(), 7'b0} | {25'b0, pool[$urandom_range(0, 9)]};
    // Bias funct7 toward the legal encodings so legal R/shift ops are common.
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_ctrl"}, {28'b0, out_alu_ctrl}, {28'b0, v.ctrl});
    chk({tag, "_sela"}, {31'b0, out_sel_a_pc}, {31'b0, v.sela});
    chk({tag, "_selb"}, {31'b0, out_sel_b_imm}, {31'b0, v.selb});
    chk({tag, "_imm"}, out_imm, v.imm);
    chk({tag, "_ill"}, {31'b0, out_illegal}, {31'b0, v.ill});
    chk({tag, "_pc"}, out_pc, v.pc);
  endtask

  initial begin
    exp_t        e;
    logic        exp_v;
    logic [31:0] exp_pc;

    vecs[0]  = mk(32'h003100B3, 32'h000, C_ADD,   0, 0, 32'h0,        0);
    vecs[1]  = mk(32'h403100B3, 32'h004, C_SUB,   0, 0, 32'h0,        0);
    vecs[2]  = mk(32'h40315093, 32'h008, C_SRA,   0, 1, 32'h3,        0);
    vecs[3]  = mk(32'h123450B7, 32'h00C, C_PASSB, 0, 1, 32'h12345000, 0);
    vecs[4]  = mk(32'h12345097, 32'h100, C_ADD,   1, 1, 32'h12345000, 0);
    vecs[5]  = mk(32'h023100B3, 32'h104, C_ADD,   0, 0, 32'h0,        1);
    vecs[6]  = mk(32'h00314463, 32'h108, C_SLT,   0, 0, 32'h8,        0);
    vecs[7]  = mk(32'h00317463, 32'h10C, C_SLTU,  0, 0, 32'h8,        0);
    vecs[8]  = mk(32'hFFF10093, 32'h110, C_ADD,   0, 1, 32'hFFFFFFFF, 0);
    vecs[9]  = mk(32'h02011093, 32'h114, C_ADD,   0, 0, 32'h0,        1);
    vecs[10] = mk(32'h00312223, 32'h118, C_ADD,   0, 1, 32'h4,        0);
    vecs[11] = mk(32'hFFDFF06F, 32'h11C, C_ADD,   1, 1, 32'hFFFFFFFC, 0);
    vecs[12] = mk(32'h0000007F, 32'h120, C_ADD,   0, 0, 32'h0,        1);
    vecs[13] = mk(32'h00312463, 32'h124, C_ADD,   0, 0, 32'h0,        1);
    vecs[14] = mk(32'h403150B3, 32'h128, C_SRA,   0, 0, 32'h0,        0);
    vecs[15] = mk(32'h403160B3, 32'h12C, C_ADD,   0, 0, 32'h0,        1);

    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_ill", {31'b0, out_illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i]);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Stall: held op A stays bit-exact while B waits, then B follows exactly once.
    in_valid = 1'b1; out_ready = 1'b1; in_instr = vecs[3].instr; in_pc = 32'h40;
    tick();
    in_instr = vecs[1].instr; in_pc = 32'h80; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      chk_out("stall_hold", mk(0, 32'h40, C_PASSB, 0, 1, 32'h12345000, 0));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("release_next", mk(0, 32'h80, C_SUB, 0, 0, 32'h0, 0));
    in_valid = 1'b0;
    tick();
    chk("release_no_dup", {31'b0, out_valid}, 32'd0);

    // Flush while stalled with an incoming op: both are dropped.
    in_valid = 1'b1; in_instr = vecs[0].instr; in_pc = 32'h200;
    tick();
    out_ready = 1'b0; in_instr = vecs[1].instr; flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_after", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a stall discards the held op.
    in_valid = 1'b1; in_instr = vecs[3].instr; in_pc = 32'h300;
    tick();
    out_ready = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rststall_valid", {31'b0, out_valid}, 32'd0);
    chk("rststall_ctrl", {28'b0, out_alu_ctrl}, 32'd0);
    chk("rststall_imm", out_imm, 32'd0);
    chk("rststall_ill", {31'b0, out_illegal}, 32'd0);
    chk("rststall_pc", out_pc, 32'd0);
    chk("rststall_in_ready", {31'b0, in_ready}, 32'd1);

    // Randomized traffic against the reference model (single-entry scoreboard).
    exp_v = 1'b0; exp_pc = 32'h0; e = ref_model(32'h0);
    out_ready = 1'b1;
    tick();
    for (int n = 0; n < 400; n++) begin
      chk("rnd_valid", {31'b0, out_valid}, {31'b0, exp_v});
      if (exp_v) begin
        chk("rnd_ctrl", {28'b0, out_alu_ctrl}, {28'b0, e.ctrl});
        chk("rnd_sela", {31'b0, out_sel_a_pc}, {31'b0, e.sela});
        chk("rnd_selb", {31'b0, out_sel_b_imm}, {31'b0, e.selb});
        chk("rnd_imm", out_imm, e.imm);
        chk("rnd_ill", {31'b0, out_illegal}, {31'b0, e.ill});
        chk("rnd_pc", out_pc, exp_pc);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = gen_instr();
      in_pc     = $urandom() & 32'hFFFF_FFFC;
      #1;
      chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, (!exp_v || out_ready)});
      if (flush) begin
        exp_v = 1'b0;
      end else if (in_valid && (!exp_v || out_ready)) begin
        e = ref_model(in_instr); exp_pc = in_pc; exp_v = 1'b1;
      end else if (out_ready) begin
        exp_v = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
